// File: rtl/bmp_stream_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bmp_stream_writer                                             |
// | Purpose  : Turns an 8-bit grayscale pixel FIFO into a 24-bit BMP byte     |
// |            stream (54-byte header, B=G=R pixels, rows padded to 4 bytes). |
// |            Header generation is compiled in only when the macro           |
// |            BMP_HEADER_GEN_EN is defined; otherwise raw padded pixel data. |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module bmp_stream_writer #(
    parameter int IMG_WIDTH  = 720,
    parameter int IMG_HEIGHT = 540,
    parameter int PIX_DWIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [PIX_DWIDTH-1:0] in_dout,
    input  logic                  in_empty,
    output logic                  in_rd_en,
    output logic [7:0]            out_din,
    input  logic                  out_full,
    output logic                  out_wr_en,
    output logic                  frame_done
);

    localparam int          c_cnt_w     = $clog2(4096);
    localparam int unsigned c_row_bytes = 3 * IMG_WIDTH;
    localparam int unsigned c_stride    = ((c_row_bytes + 3) / 4) * 4;
    localparam int unsigned c_pad       = c_stride - c_row_bytes;
    localparam bit          c_has_pad   = (c_pad != 0);

    localparam logic [c_cnt_w-1:0] c_last_col = c_cnt_w'(IMG_WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_last_row = c_cnt_w'(IMG_HEIGHT - 1);
    localparam logic [c_cnt_w-1:0] c_one      = c_cnt_w'(1);
    localparam logic [1:0]         c_last_pad = 2'((c_pad == 0) ? 0 : c_pad - 1);

    localparam logic [1:0] c_st_pixel  = 2'd0;
    localparam logic [1:0] c_st_pad    = 2'd1;
    localparam logic [1:0] c_st_done   = 2'd2;
`ifdef BMP_HEADER_GEN_EN
    localparam logic [1:0] c_st_header = 2'd3;
    localparam logic [1:0] c_st_start  = c_st_header;

    localparam logic [31:0] c_img_size  = 32'(c_stride * IMG_HEIGHT);
    localparam logic [31:0] c_file_size = c_img_size + 32'd54;
`else
    localparam logic [1:0] c_st_start  = c_st_pixel;
`endif

    logic [1:0]         r_state;
    logic [1:0]         r_sub;
    logic [c_cnt_w-1:0] r_col;
    logic [c_cnt_w-1:0] r_row;
    logic [1:0]         r_pad;

    logic [1:0]         w_state_nxt;
    logic [1:0]         w_sub_nxt;
    logic [c_cnt_w-1:0] w_col_nxt;
    logic [c_cnt_w-1:0] w_row_nxt;
    logic [1:0]         w_pad_nxt;

    logic               w_emit;
    logic               w_wr;
    logic               w_row_end;
    logic [7:0]         w_byte;

`ifdef BMP_HEADER_GEN_EN
    logic [5:0]  r_idx;
    logic [5:0]  w_idx_nxt;
    logic [31:0] w_hdr_field;
    logic [5:0]  w_hdr_base;
    logic [1:0]  w_hdr_off;
    logic [7:0]  w_hdr_byte;

    // Each header field is a little-endian word; pick the field, then the byte within it.
    always_comb begin
        w_hdr_field = 32'd0;
        w_hdr_base  = 6'd0;
        if (r_idx < 6'd2) begin
            w_hdr_field = 32'h0000_4D42;
        end else if (r_idx < 6'd6) begin
            w_hdr_field = c_file_size;
            w_hdr_base  = 6'd2;
        end else if (r_idx < 6'd10) begin
            w_hdr_base  = 6'd6;
        end else if (r_idx < 6'd14) begin
            w_hdr_field = 32'd54;
            w_hdr_base  = 6'd10;
        end else if (r_idx < 6'd18) begin
            w_hdr_field = 32'd40;
            w_hdr_base  = 6'd14;
        end else if (r_idx < 6'd22) begin
            w_hdr_field = 32'(IMG_WIDTH);
            w_hdr_base  = 6'd18;
        end else if (r_idx < 6'd26) begin
            w_hdr_field = 32'(IMG_HEIGHT);
            w_hdr_base  = 6'd22;
        end else if (r_idx < 6'd28) begin
            w_hdr_field = 32'd1;
            w_hdr_base  = 6'd26;
        end else if (r_idx < 6'd30) begin
            w_hdr_field = 32'd24;
            w_hdr_base  = 6'd28;
        end else if (r_idx < 6'd34) begin
            w_hdr_base  = 6'd30;
        end else if (r_idx < 6'd38) begin
            w_hdr_field = c_img_size;
            w_hdr_base  = 6'd34;
        end else if (r_idx < 6'd42) begin
            w_hdr_field = 32'd2835;
            w_hdr_base  = 6'd38;
        end else if (r_idx < 6'd46) begin
            w_hdr_field = 32'd2835;
            w_hdr_base  = 6'd42;
        end else begin
            w_hdr_base  = 6'd46;
        end
        w_hdr_off  = 2'(r_idx - w_hdr_base);
        w_hdr_byte = w_hdr_field[{w_hdr_off, 3'b000} +: 8];
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_st_start;
            r_sub   <= 2'd0;
            r_col   <= '0;
            r_row   <= '0;
            r_pad   <= 2'd0;
`ifdef BMP_HEADER_GEN_EN
            r_idx   <= 6'd0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_sub   <= w_sub_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            r_pad   <= w_pad_nxt;
`ifdef BMP_HEADER_GEN_EN
            r_idx   <= w_idx_nxt;
`endif
        end
    end

    always_comb begin
        w_emit = 1'b0;
        w_byte = 8'h00;
        case (r_state)
`ifdef BMP_HEADER_GEN_EN
            c_st_header: begin
                w_emit = 1'b1;
                w_byte = w_hdr_byte;
            end
`endif
            c_st_pixel: begin
                w_emit = ~in_empty;
                w_byte = in_dout[7:0];
            end
            c_st_pad: w_emit = 1'b1;
            default:  w_emit = 1'b0;
        endcase

        // Outputs are forced quiet while reset is held so nothing leaks mid-reset.
        w_wr       = w_emit & ~out_full & ~reset;
        out_wr_en  = w_wr;
        out_din    = w_wr ? w_byte : 8'h00;
        in_rd_en   = w_wr & (r_state == c_st_pixel) & (r_sub == 2'd2);
        frame_done = (r_state == c_st_done) & ~reset;

        w_state_nxt = r_state;
        w_sub_nxt   = r_sub;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_pad_nxt   = r_pad;
        w_row_end   = 1'b0;
`ifdef BMP_HEADER_GEN_EN
        w_idx_nxt   = r_idx;
`endif
        case (r_state)
`ifdef BMP_HEADER_GEN_EN
            c_st_header: begin
                if (w_wr) begin
                    if (r_idx == 6'd53) begin
                        w_idx_nxt   = 6'd0;
                        w_state_nxt = c_st_pixel;
                    end else begin
                        w_idx_nxt   = r_idx + 6'd1;
                    end
                end
            end
`endif
            c_st_pixel: begin
                if (w_wr) begin
                    if (r_sub == 2'd2) begin
                        w_sub_nxt = 2'd0;
                        if (r_col == c_last_col) begin
                            w_col_nxt = '0;
                            if (c_has_pad) w_state_nxt = c_st_pad;
                            else           w_row_end   = 1'b1;
                        end else begin
                            w_col_nxt = r_col + c_one;
                        end
                    end else begin
                        w_sub_nxt = r_sub + 2'd1;
                    end
                end
            end
            c_st_pad: begin
                if (w_wr) begin
                    if (r_pad == c_last_pad) begin
                        w_pad_nxt = 2'd0;
                        w_row_end = 1'b1;
                    end else begin
                        w_pad_nxt = r_pad + 2'd1;
                    end
                end
            end
            c_st_done: begin
                w_state_nxt = c_st_start;
                w_sub_nxt   = 2'd0;
                w_col_nxt   = '0;
                w_row_nxt   = '0;
                w_pad_nxt   = 2'd0;
            end
            default: w_state_nxt = c_st_start;
        endcase

        // End-of-row is a transition, not a state, so rows cost no extra cycle.
        if (w_row_end) begin
            if (r_row == c_last_row) begin
                w_row_nxt   = '0;
                w_state_nxt = c_st_done;
            end else begin
                w_row_nxt   = r_row + c_one;
                w_state_nxt = c_st_pixel;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/bmp_stream_writer.md
# bmp_stream_writer

Serializes the 8-bit Sobel pixel stream into a complete 24-bit BMP byte stream: a generated 54-byte header, then each grayscale pixel replicated as B,G,R, with rows zero-padded to a 4-byte boundary. It sits at the output of `dut_system`. It pops the Sobel FIFO and pushes bytes into a byte-wide output FIFO, so the hardware produces the same file image that the bench currently assembles in software. Frames repeat indefinitely.

## Interface
- IMG_WIDTH, 720, pixels per row (1..4095)
- IMG_HEIGHT, 540, rows per frame (1..4095); header height written positive (bottom-up order, pixels passed in arrival order)
- PIX_DWIDTH, 8, input pixel width; must be 8
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- in_dout  in  PIX_DWIDTH  pixel at head of input FIFO (first-word-fall-through)
- in_empty  in  1  input FIFO empty
- in_rd_en  out  1  pop input FIFO; reset 0
- out_din  out  8  byte to output FIFO; reset 0
- out_full  in  1  output FIFO full
- out_wr_en  out  1  push output FIFO; reset 0
- frame_done  out  1  one-cycle pulse after final byte of a frame; reset 0

## Operation
- Derived constants: STRIDE = 3·IMG_WIDTH rounded up to a multiple of 4; PAD = STRIDE − 3·IMG_WIDTH (0..3); IMG_SIZE = STRIDE·IMG_HEIGHT; FILE_SIZE = IMG_SIZE + 54. All are 32-bit and little-endian in the header.
- Header bytes 0..53, in order:
  - 'B' 'M'
  - FILE_SIZE, 4 bytes
  - 0, 4 bytes
  - 54, 4 bytes
  - 40, 4 bytes
  - IMG_WIDTH, 4 bytes
  - IMG_HEIGHT, 4 bytes
  - 1, 2 bytes
  - 24, 2 bytes
  - 0, 4 bytes
  - IMG_SIZE, 4 bytes
  - 2835, 4 bytes
  - 2835, 4 bytes
  - 0, 4 bytes
  - 0, 4 bytes
- Header bytes come from a combinational lookup on a 6-bit index.
- States:
  - HEADER: emits byte[idx]; idx advances per accepted write; after idx 53 → PIXEL.
  - PIXEL: sub-counter 0..2. out_din = in_dout. On the sub 2 write, pop the input and advance the column. After the last column → PAD if PAD≠0, otherwise end-of-row.
  - PAD: emits PAD zero bytes → end-of-row.
  - End-of-row: row advances. After the last row → DONE, otherwise PIXEL with column 0.
  - DONE: one cycle; frame_done=1; no writes. Then → HEADER with all counters cleared.
- Write rule: out_wr_en = state emits ∧ ¬out_full ∧ (state≠PIXEL ∨ ¬in_empty). A byte is accepted exactly when out_wr_en=1.
- in_rd_en = out_wr_en ∧ PIXEL ∧ sub==2. The input is never popped at any other time.
- out_din and out_wr_en are combinational from registered state plus the handshake inputs. out_din is 0 whenever out_wr_en=0.
- Counter widths: column and row $clog2(4096)=12 bits; pad counter 2 bits.

## Timing
- Throughput: one byte per cycle with no stalls.
- Unstalled frame: 54 + IMG_SIZE write cycles, then 1 DONE cycle.
- Latency: first header byte is offered on the first cycle after reset deasserts.
- out_full stall: all counters hold; the same byte is re-offered; no pop.
- in_empty stall in PIXEL: stalls without a write. It has no effect in HEADER, PAD or DONE.
- in_empty and out_full together: stall; nothing changes.
- Reset mid-frame: on the next edge all outputs go to 0 and the state returns to HEADER idx 0.
  - The partial frame is abandoned.
  - The input FIFO is not flushed.
  - A partially emitted pixel is re-emitted from its B byte, because the pixel was not popped.

## Configuration
- BMP_HEADER_GEN_EN defined: behaviour as above.
- BMP_HEADER_GEN_EN undefined:
  - HEADER state and header lookup are compiled out.
  - Reset and post-DONE state is PIXEL.
  - The stream is raw padded pixel data, IMG_SIZE bytes per frame, followed by the DONE cycle.

## Test plan
- W=3, H=2, pixels 10..15h, no backpressure → 78 bytes:
  - Header: 42 4D 4E 00 00 00 … (byte 34..37 = 18 00 00 00).
  - Data: 10 10 10 11 11 11 12 12 12 00 00 00 13 13 13 … 15 15 15 00 00 00.
  - frame_done pulses on cycle 79. A second frame starts with 42 on cycle 80.
- Same frame with out_full high for 5 cycles on the second byte of pixel 11h → no writes, no pops; resumes with byte 11; stream identical to the first scenario.
- in_empty held high from reset for 100 cycles → all 54 header bytes written; then out_wr_en=0 and in_rd_en=0 until data arrives.
- W=720, H=540 → PAD=0; header bytes 2..5 = 76 CC 11 00; bytes 34..37 = 40 CC 11 00; 1166454 bytes per frame.
- Reset asserted on the second byte of a pixel → next cycle out_wr_en=0, in_rd_en=0, frame_done=0; then out_din=42h; after the header, the same unpopped pixel is emitted as B.
- BMP_HEADER_GEN_EN undefined, W=3, H=2 → first byte 10h; 24 bytes per frame; frame_done on cycle 25.
